// File: rtl/fir_filter_param.sv
// Parametrised, fully pipelined direct-form FIR filter with AXI-Stream
// handshakes on both sides, a double-buffered runtime coefficient bank,
// a registered binary adder tree and a round/shift/saturate output stage.
// Pipeline: delay line -> multiply -> TREE_ST adder levels -> output register.
module fir_filter_param #(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    parameter int NUM_TAPS = 16,
    parameter int OUT_W    = 32,
    parameter int SHIFT    = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [DATA_W-1:0]      s_axis_fir_tdata,
    input  logic                          s_axis_fir_tvalid,
    output logic                          s_axis_fir_tready,
    output logic signed [OUT_W-1:0]       m_axis_fir_tdata,
    output logic                          m_axis_fir_tvalid,
    input  logic                          m_axis_fir_tready,
    input  logic                          coef_wr_en,
    input  logic [$clog2(NUM_TAPS)-1:0]   coef_wr_addr,
    input  logic signed [COEF_W-1:0]      coef_wr_data,
    input  logic                          coef_swap
);

    localparam int TREE_ST = $clog2(NUM_TAPS);
    localparam int PROD_W  = DATA_W + COEF_W;
    localparam int ACC_W   = DATA_W + COEF_W + TREE_ST;
    // Leaves padded to a power of two; padding leaves are tied to zero.
    localparam int POW     = 32'sd2 ** TREE_ST;
    // Wide enough for the rounding carry and for the output range itself.
    localparam int EXT_W   = ((ACC_W + 32'sd1 > OUT_W) ? ACC_W + 32'sd1 : OUT_W) + 32'sd1;

    localparam logic [EXT_W-1:0]        ONE_C     = {{(EXT_W-1){1'b0}}, 1'b1};
    // Half an LSB of the shifted result; zero when no shift is applied.
    localparam logic [EXT_W-1:0]        RND_C     = (ONE_C << SHIFT) >> 1'b1;
    localparam logic signed [EXT_W-1:0] SAT_MAX_C = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN_C = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Handshake
    logic en_s;
    logic accept_s;

    // Coefficient banks
    logic signed [COEF_W-1:0] shadow_q [NUM_TAPS];
    logic signed [COEF_W-1:0] shadow_d [NUM_TAPS];
    logic signed [COEF_W-1:0] active_q [NUM_TAPS];
    logic signed [COEF_W-1:0] active_d [NUM_TAPS];

    // Stage 0: delay line
    logic signed [DATA_W-1:0] x_q [NUM_TAPS];
    logic signed [DATA_W-1:0] x_d [NUM_TAPS];
    logic                     v0_q, v0_d;

    // Stage 1: products
    logic signed [PROD_W-1:0] p_q [NUM_TAPS];
    logic signed [PROD_W-1:0] p_d [NUM_TAPS];
    logic                     v1_q, v1_d;

    // Adder tree stored heap-style: node i sums nodes 2i and 2i+1,
    // nodes POW..2*POW-1 are the (combinational) leaves, node 1 is the root.
    logic signed [ACC_W-1:0]  leaf_s [POW];
    logic signed [ACC_W-1:0]  node_s [2:2*POW-1];
    logic signed [ACC_W-1:0]  tree_q [1:POW-1];
    logic signed [ACC_W-1:0]  tree_d [1:POW-1];
    logic [TREE_ST-1:0]       vt_q, vt_d;

    // Output stage
    logic signed [EXT_W-1:0]  sum_ext_s, rnd_s, shf_s;
    logic signed [OUT_W-1:0]  y_q, y_d;
    logic                     y_vld_q, y_vld_d;

    assign en_s              = m_axis_fir_tready | ~y_vld_q;
    assign accept_s          = s_axis_fir_tvalid & en_s;
    assign s_axis_fir_tready = en_s;
    assign m_axis_fir_tdata  = y_q;
    assign m_axis_fir_tvalid = y_vld_q;

    // Sign-extend the products into the tree leaves, zero the padding leaves.
    for (genvar g = 0; g < POW; g++) begin : g_leaf
        if (g < NUM_TAPS) begin : g_used
            assign leaf_s[g] = ACC_W'(p_q[g]);
        end else begin : g_pad
            assign leaf_s[g] = '0;
        end
    end

    // Shadow bank write and shadow-to-active swap (a same-cycle write is swapped in).
    always_comb begin
        shadow_d = shadow_q;
        if (coef_wr_en && (int'(coef_wr_addr) < NUM_TAPS)) begin
            shadow_d[coef_wr_addr] = coef_wr_data;
        end else begin
            shadow_d = shadow_q;
        end
        if (coef_swap) begin
            active_d = shadow_d;
        end else begin
            active_d = active_q;
        end
    end

    // Delay line shifts only on accepted beats; valid/products advance on en.
    always_comb begin
        x_d  = x_q;
        v0_d = v0_q;
        p_d  = p_q;
        v1_d = v1_q;
        if (accept_s) begin
            x_d[0] = s_axis_fir_tdata;
            for (int k = 32'sd1; k < NUM_TAPS; k++) begin
                x_d[k] = x_q[k-1];
            end
        end else begin
            x_d = x_q;
        end
        if (en_s) begin
            v0_d = accept_s;
            v1_d = v0_q;
            for (int k = 32'sd0; k < NUM_TAPS; k++) begin
                p_d[k] = PROD_W'(x_q[k]) * PROD_W'(active_q[k]);
            end
        end else begin
            v0_d = v0_q;
            v1_d = v1_q;
            p_d  = p_q;
        end
    end

    // Registered pairwise adds, one tree level per clock, with valid alongside.
    always_comb begin
        for (int i = 32'sd2; i < POW; i++) begin
            node_s[i] = tree_q[i];
        end
        for (int i = 32'sd0; i < POW; i++) begin
            node_s[POW+i] = leaf_s[i];
        end
        tree_d = tree_q;
        vt_d   = vt_q;
        if (en_s) begin
            for (int i = 32'sd1; i < POW; i++) begin
                tree_d[i] = node_s[2*i] + node_s[2*i+1];
            end
            vt_d[0] = v1_q;
            for (int l = 32'sd1; l < TREE_ST; l++) begin
                vt_d[l] = vt_q[l-1];
            end
        end else begin
            tree_d = tree_q;
            vt_d   = vt_q;
        end
    end

    // Round half up, arithmetic shift, then clamp to the signed output range.
    always_comb begin
        sum_ext_s = EXT_W'(tree_q[1]);
        rnd_s     = sum_ext_s + $signed(RND_C);
        shf_s     = rnd_s >>> SHIFT;
        y_d       = y_q;
        y_vld_d   = y_vld_q;
        if (en_s) begin
            y_vld_d = vt_q[TREE_ST-1];
            if (shf_s > SAT_MAX_C) begin
                y_d = SAT_MAX_C[OUT_W-1:0];
            end else if (shf_s < SAT_MIN_C) begin
                y_d = SAT_MIN_C[OUT_W-1:0];
            end else begin
                y_d = shf_s[OUT_W-1:0];
            end
        end else begin
            y_d     = y_q;
            y_vld_d = y_vld_q;
        end
    end

    // State update; reset clears the datapath and restores identity coefficients.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 32'sd0; k < NUM_TAPS; k++) begin
                x_q[k]      <= '0;
                p_q[k]      <= '0;
                shadow_q[k] <= (k == 32'sd0) ? {{(COEF_W-1){1'b0}}, 1'b1} : '0;
                active_q[k] <= (k == 32'sd0) ? {{(COEF_W-1){1'b0}}, 1'b1} : '0;
            end
            for (int i = 32'sd1; i < POW; i++) begin
                tree_q[i] <= '0;
            end
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            vt_q    <= '0;
            y_q     <= '0;
            y_vld_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            p_q      <= p_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            tree_q   <= tree_d;
            v0_q     <= v0_d;
            v1_q     <= v1_d;
            vt_q     <= vt_d;
            y_q      <= y_d;
            y_vld_q  <= y_vld_d;
        end
    end

endmodule

// File: doc/fir_filter_param.md
Name: fir_filter_param

Overview:
- Parametrised, fully pipelined direct-form FIR with a registered adder tree.
- Successor to the fixed 16-bit-in / 32-bit-out fir_filter. Adds generic width and tap count, true AXI-Stream backpressure on both sides, and a runtime-loadable double-buffered coefficient bank.
- Adds a configurable output scaling stage with rounding and saturation.
- Sits between the sample source and downstream DSP, on the same single clock domain.

Parameters:
- DATA_W, 16: signed input sample width.
- COEF_W, 16: signed coefficient width.
- NUM_TAPS, 16: number of taps, 2..64.
- OUT_W, 32: signed output width.
- SHIFT, 0: arithmetic right shift applied to the full-precision sum before saturation, 0..ACC_W-1.
- Derived: ACC_W = DATA_W+COEF_W+clog2(NUM_TAPS); TREE_ST = clog2(NUM_TAPS); LATENCY = 3+TREE_ST (7 at defaults).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_axis_fir_tdata  in  DATA_W  signed input sample.
- s_axis_fir_tvalid  in  1  input sample valid.
- s_axis_fir_tready  out  1  block can accept a sample.
- m_axis_fir_tdata  out  OUT_W  signed filtered output.
- m_axis_fir_tvalid  out  1  output valid.
- m_axis_fir_tready  in  1  downstream accepts output.
- coef_wr_en  in  1  write shadow coefficient.
- coef_wr_addr  in  clog2(NUM_TAPS)  tap index.
- coef_wr_data  in  COEF_W  signed coefficient.
- coef_swap  in  1  copy shadow bank to active bank.

Behaviour:
- Reset state (rst=1 at a clock edge):
  - Delay line, all pipeline data and all valid bits cleared.
  - m_axis_fir_tdata=0, m_axis_fir_tvalid=0.
  - s_axis_fir_tready=1 in the cycle after reset.
  - Active and shadow banks both reset to h[0]=1, h[1..N-1]=0, i.e. pass-through with latency.
  - rst overrides every other input, including coef writes and swap.
- Global enable: en = m_axis_fir_tready | ~m_axis_fir_tvalid. s_axis_fir_tready = en (combinational from m_axis_fir_tready and the registered m_axis_fir_tvalid).
- Stage 0 (delay line): on an accepted beat (s_axis_fir_tvalid & s_axis_fir_tready) the sample shifts into x[0] and x[k] <= x[k-1]. With no accepted beat the line holds; bubbles never enter the delay line.
- Stage 1 (multiply): p[k] = x[k]*h_active[k], full precision DATA_W+COEF_W.
- Stages 2..1+TREE_ST (adder tree): pairwise registered adds, sign-extended to ACC_W.
  - Odd element counts pass the odd element through a register so all paths stay aligned.
  - Unused leaves for non-power-of-2 NUM_TAPS are zero.
- Final stage: y = (sum + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT (round half up), then saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - If ACC_W-SHIFT <= OUT_W, sign-extend instead of saturating.
  - Result registered into m_axis_fir_tdata.
- Valid bit travels with data through every stage.
  - All stages advance only when en=1; when en=0 every stage, including m_axis_fir_tdata/tvalid, holds.
  - Exactly one output per accepted input, in order. First output appears LATENCY edges after acceptance when unstalled.
- Coefficients:
  - coef_wr_en writes the shadow bank at coef_wr_addr at the clock edge.
  - coef_swap copies the whole shadow bank to the active bank at the same edge, regardless of en.
  - If coef_wr_en and coef_swap occur in the same cycle, the written value is included in the swap.
  - The active bank feeds stage 1, so a sample multiplied at the edge after the swap uses the new bank. Samples already past stage 1 keep the old products.
- Reset mid-stream: in-flight samples are discarded (no output for them) and the delay line history is zeroed.

Test Plan:
- Pass-through: reset, drive 5,-7,32767,-32768 back-to-back with m_tready=1 -> outputs 5,-7,32767,-32768; the first appears 7 cycles after its input was accepted; tvalid is high for exactly 4 cycles.
- Impulse: load h[k]=k+1 (k=0..15), swap, input 1 then 15 zeros -> outputs 1,2,...,16 in order; a following zero input gives 0.
- Saturation: all h=32767, input 32767 x16 -> 16th output 2147483647; input -32768 x16 -> 16th output -2147483648.
- Backpressure: random m_tready (about 50% duty) with continuous s_tvalid -> output sequence identical to the unstalled run; m_tdata and m_tvalid stable while m_tready=0; s_tready=0 whenever tvalid=1 and m_tready=0.
- Coefficient swap mid-stream: constant input 100 with identity coefs, write h[0]=2 and swap at sample 20 -> outputs 100 up to the last sample multiplied before the swap edge, then 200; no other values appear.
- Reset mid-operation: assert rst for 1 cycle while 5 samples are in flight -> no outputs for them; tvalid=0; coefs back to identity; the next input 9 yields 9.
